// File: rtl/bus_pkg.sv
// Shared definitions for the peripheral bus master.
// Peripheral select codes, bus widths and the sequencer state encoding.
package bus_pkg;

    localparam logic [3:0]  RAM_PERIPH  = 4'h0;
    localparam logic [3:0]  IDLE_PERIPH = 4'hF;
    localparam int          BUS_W       = 256;
    localparam int          ADDR_W      = 16;
    localparam int          MAX_LEN     = 16;
    localparam logic [15:0] IDLE_ADDR   = {IDLE_PERIPH, 12'h000};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_TURN,
        S_WR
    } state_t;

    // A burst may not target the idle code nor run past the end of a peripheral.
    function automatic logic req_bad(input logic [15:0] a, input logic [3:0] len);
        logic [12:0] w_end;
        w_end = {1'b0, a[11:0]} + {9'b0, len};
        return (a[15:12] == IDLE_PERIPH) || (w_end > 13'h0FFF);
    endfunction

endpackage

// File: rtl/bus_driver.sv
// Registered tri-state driver for the shared peripheral bus.
// Enable and data are both flopped so the bus changes only on rising edges.
module bus_driver
    import bus_pkg::*;
(
    input  logic             clk,
    input  logic             nReset,
    input  logic             i_oe,
    input  logic [BUS_W-1:0] i_data,
    inout  wire  [BUS_W-1:0] io_bus
);

    logic             r_oe;
    logic [BUS_W-1:0] r_data;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_oe   <= 1'b0;
            r_data <= '0;
        end else begin
            r_oe   <= i_oe;
            r_data <= i_data;
        end
    end

    assign io_bus = r_oe ? r_data : {BUS_W{1'bz}};

endmodule

// File: rtl/mem_bus_master.sv
// Burst load/store sequencer for the 256-bit shared peripheral bus.
// Runs on the rising edge; peripherals answer on the falling edge.
module mem_bus_master
    import bus_pkg::*;
(
    input  logic              clk,
    input  logic              nReset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_len,
    input  logic [BUS_W-1:0]  wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [BUS_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] addr,
    output logic              nRead,
    output logic              nWrite,
    inout  wire  [BUS_W-1:0]  bus
);

    state_t             r_state, w_state;
    logic [ADDR_W-1:0]  r_addr, w_addr;
    logic [ADDR_W-1:0]  r_start, w_start;
    logic               r_nread, w_nread;
    logic               r_nwrite, w_nwrite;
    logic [BUS_W-1:0]   r_rd_data, w_rd_data;
    logic               r_rd_valid, w_rd_valid;
    logic               r_rd_last, w_rd_last;
    logic               r_done, w_done;
    logic               r_err, w_err;
    logic [4:0]         r_cnt, w_cnt;
    logic [3:0]         r_len, w_len;
    logic               w_oe;
    logic               w_rem;

    bus_driver u_drv (
        .clk    (clk),
        .nReset (nReset),
        .i_oe   (w_oe),
        .i_data (wdata),
        .io_bus (bus)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state    <= S_IDLE;
            r_addr     <= IDLE_ADDR;
            r_start    <= IDLE_ADDR;
            r_nread    <= 1'b1;
            r_nwrite   <= 1'b1;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_len      <= '0;
        end else begin
            r_state    <= w_state;
            r_addr     <= w_addr;
            r_start    <= w_start;
            r_nread    <= w_nread;
            r_nwrite   <= w_nwrite;
            r_rd_data  <= w_rd_data;
            r_rd_valid <= w_rd_valid;
            r_rd_last  <= w_rd_last;
            r_done     <= w_done;
            r_err      <= w_err;
            r_cnt      <= w_cnt;
            r_len      <= w_len;
        end
    end

    assign w_rem = (r_cnt <= {1'b0, r_len});

    always_comb begin
        w_state     = r_state;
        w_addr      = r_addr;
        w_start     = r_start;
        w_nread     = r_nread;
        w_nwrite    = r_nwrite;
        w_rd_data   = r_rd_data;
        w_rd_valid  = 1'b0;
        w_rd_last   = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_cnt       = r_cnt;
        w_len       = r_len;
        w_oe        = 1'b0;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad(req_addr, req_len)) begin
                        w_err = 1'b1;
                    end else begin
                        w_len   = req_len;
                        w_cnt   = '0;
                        w_start = req_addr;
                        if (req_write) begin
                            w_state = S_WR;
                        end else begin
                            w_addr  = req_addr;
                            w_nread = 1'b0;
                            w_state = S_RD;
                        end
                    end
                end
            end
            S_RD: begin
                w_rd_data  = bus;
                w_rd_valid = 1'b1;
                w_cnt      = r_cnt + 5'd1;
                if (r_cnt[3:0] == r_len) begin
                    w_rd_last = 1'b1;
                    w_done    = 1'b1;
                    w_addr    = IDLE_ADDR;
                    w_nread   = 1'b1;
                    w_state   = S_TURN;
                end else begin
                    w_addr = {r_addr[15:12], r_addr[11:0] + 12'd1};
                end
            end
            // Gives the peripheral a falling edge to release the bus.
            S_TURN: begin
                w_state = S_IDLE;
            end
            S_WR: begin
                wdata_ready = w_rem;
                if (!w_rem) begin
                    w_nwrite = 1'b1;
                    w_addr   = IDLE_ADDR;
                    w_done   = 1'b1;
                    w_state  = S_IDLE;
                end else if (wdata_valid) begin
                    w_addr   = {r_start[15:12], r_start[11:0] + {7'b0, r_cnt}};
                    w_oe     = 1'b1;
                    w_nwrite = 1'b0;
                    w_cnt    = r_cnt + 5'd1;
                end else begin
                    w_nwrite = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign rd_last  = r_rd_last;
    assign done     = r_done;
    assign err      = r_err;
    assign addr     = r_addr;
    assign nRead    = r_nread;
    assign nWrite   = r_nwrite;

endmodule
